// File: rtl/led_seg_output.sv
// led_seg_output: MMIO store decode into LED and display registers, plus an
// 8-digit common-anode hex scanner driving active-low anodes and segments.
module led_seg_output #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ioWrite,
    input  logic [31:0] address,
    input  logic [15:0] dataIOOutput,
    output logic [15:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);
    logic [15:0]      led_q, led_d;
    logic [31:0]      value_q, value_d;
    logic [7:0]       mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       dig_q, dig_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       nib;
    logic [6:0]       font;
    logic             wrap;

    always_comb begin
        led_d   = led_q;
        value_d = value_q;
        mask_d  = mask_q;
        if (ioWrite) begin
            led_d   = address == 32'hffff_ffc1 ? dataIOOutput :
                      address == 32'hffff_ffc3 ? {dataIOOutput[7:0], led_q[7:0]} :
                      address == 32'hffff_ffc5 ? {led_q[15:8], dataIOOutput[7:0]} : led_q;
            value_d = address == 32'hffff_ffd1 ? {value_q[31:16], dataIOOutput} :
                      address == 32'hffff_ffd3 ? {dataIOOutput, value_q[15:0]} : value_q;
            mask_d  = address == 32'hffff_ffd5 ? dataIOOutput[7:0] : mask_q;
        end
        wrap  = cnt_q == CNT_W'(SCAN_DIV - 1);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        dig_d = wrap ? dig_q + 3'd1 : dig_q;
        nib   = value_q[{dig_q, 2'b00} +: 4];
        case (nib)
            4'h0: font = 7'b1000000;
            4'h1: font = 7'b1111001;
            4'h2: font = 7'b0100100;
            4'h3: font = 7'b0110000;
            4'h4: font = 7'b0011001;
            4'h5: font = 7'b0010010;
            4'h6: font = 7'b0000010;
            4'h7: font = 7'b1111000;
            4'h8: font = 7'b0000000;
            4'h9: font = 7'b0010000;
            4'hA: font = 7'b0001000;
            4'hB: font = 7'b0000011;
            4'hC: font = 7'b1000110;
            4'hD: font = 7'b0100001;
            4'hE: font = 7'b0000110;
            default: font = 7'b0001110;
        endcase
        // Decimal point is never driven, so bit 7 stays dark.
        an_d  = mask_q[dig_q] ? ~(8'b1 << dig_q) : 8'hFF;
        seg_d = mask_q[dig_q] ? {1'b1, font} : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q   <= '0;
            value_q <= '0;
            mask_q  <= 8'hFF;
            cnt_q   <= '0;
            dig_q   <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
        end else begin
            led_q   <= led_d;
            value_q <= value_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign led     = led_q;
    assign seg_an  = an_q;
    assign seg_out = seg_q;
endmodule

// File: tb/tb_led_seg_output.sv
// tb_led_seg_output: scoreboard bench; a cycle-count model of the scanner and
// register file pushes expected outputs per edge, compared after the edge.
module tb_led_seg_output;
    localparam int DIV = 4;

    logic        clk = 0;
    logic        rst = 0;
    logic        ioWrite = 0;
    logic [31:0] address = 0;
    logic [15:0] dataIOOutput = 0;
    logic [15:0] led;
    logic [7:0]  seg_an, seg_out;

    led_seg_output #(.SCAN_DIV(DIV), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .ioWrite(ioWrite), .address(address),
        .dataIOOutput(dataIOOutput), .led(led), .seg_an(seg_an), .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] led;
        logic [7:0]  an;
        logic [7:0]  seg;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_led;
    logic [31:0] m_val;
    logic [7:0]  m_mask;
    int          m_t;
    logic [6:0]  font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [15:0] dat);
        exp_t e, g;
        int   d;
        rst = r; ioWrite = w; address = a; dataIOOutput = dat;
        if (!r) begin
            e = '{16'h0, 8'hFF, 8'hFF};
            m_led = 0; m_val = 0; m_mask = 8'hFF; m_t = 0;
        end else begin
            d = (m_t / DIV) % 8;
            e.an  = m_mask[d] ? ~(8'h01 << d) : 8'hFF;
            e.seg = m_mask[d] ? {1'b1, font[m_val[d*4 +: 4]]} : 8'hFF;
            if (w) begin
                if (a == 32'hffff_ffc1) m_led = dat;
                if (a == 32'hffff_ffc3) m_led[15:8] = dat[7:0];
                if (a == 32'hffff_ffc5) m_led[7:0] = dat[7:0];
                if (a == 32'hffff_ffd1) m_val[15:0] = dat;
                if (a == 32'hffff_ffd3) m_val[31:16] = dat;
                if (a == 32'hffff_ffd5) m_mask = dat[7:0];
            end
            m_t++;
            e.led = m_led;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("led", led, g.led);
        chk("seg_an", seg_an, g.an);
        chk("seg_out", seg_out, g.seg);
        chk("one_anode", $countones(~seg_an) <= 1, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    task automatic idle_to(input int phase);
        for (int i = 0; i < 64 && (m_t % (8 * DIV)) != phase; i++) step(1, 0, 0, 0);
        chk("phase_reach", m_t % (8 * DIV), phase);
    endtask

    initial begin
        m_led = 0; m_val = 0; m_mask = 8'hFF; m_t = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(0, 1, 32'hffff_ffc1, 16'hFFFF);
        chk("rst_led", led, 16'h0000);
        idle(2);
        chk("rel_led", led, 16'h0000);
        step(1, 1, 32'hffff_ffc1, 16'hA5C3);
        chk("led_full", led, 16'hA5C3);
        step(1, 1, 32'hffff_ffc3, 16'h0012);
        chk("led_hi", led, 16'h12C3);
        step(1, 1, 32'hffff_ffc5, 16'h0034);
        chk("led_lo", led, 16'h1234);
        step(1, 1, 32'hffff_ffc7, 16'hFFFF);
        chk("led_bad_addr", led, 16'h1234);
        step(1, 0, 32'hffff_ffc1, 16'h0000);
        chk("led_no_wr", led, 16'h1234);
        step(1, 1, 32'hffff_ffd1, 16'hCDEF);
        step(1, 1, 32'hffff_ffd3, 16'h89AB);
        idle_to(0);
        step(1, 0, 0, 0);
        chk("dig0_F", seg_out, 8'h8E);
        idle_to(28);
        step(1, 0, 0, 0);
        chk("dig7_8", seg_out, 8'h80);
        idle(36);
        step(1, 1, 32'hffff_ffd5, 16'h00F0);
        idle(36);
        step(1, 1, 32'hffff_ffd5, 16'h00FF);
        idle_to(8);
        step(1, 1, 32'hffff_ffd1, 16'h0500);
        step(1, 0, 0, 0);
        chk("mid_upd_5", seg_out, 8'h92);
        idle(4);
        idle_to(20);
        step(0, 0, 0, 0);
        chk("mid_rst_an", seg_an, 8'hFF);
        step(1, 0, 0, 0);
        chk("restart_an", seg_an, 8'hFE);
        chk("restart_seg", seg_out, 8'hC0);
        idle(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_seg_output.md
Name: led_seg_output

Overview:
- Memory-mapped output peripheral; the write-side counterpart of the switch input block.
- CPU store cycles (ioWrite strobe, address, 16-bit data) update LED and seven-segment registers.
- Block time-multiplexes an 8-digit common-anode seven-segment display in hex.
- Sits beside the switch reader on the same MMIO decode in the top-level SoC.

Parameters:
- SCAN_DIV, 100000, clk cycles each digit stays lit; minimum 2.
- CNT_W, 17, width of scan counter; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- ioWrite  input  1  store strobe from MMIO decode; one write per high cycle
- address  input  32  store address
- dataIOOutput  input  16  store data
- led  output  16  LED drive, active-high, registered
- seg_an  output  8  digit anodes, active-low, registered; bit i = digit i
- seg_out  output  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered

Behaviour:
- Reset is sampled on the clk edge with rst==0. It sets:
  - led=0, value=0 (32-bit display register), mask=8'hFF (digit enable)
  - scan counter=0, digit index=0
  - seg_an=8'hFF, seg_out=8'hFF (all dark)
- Reset overrides a write in the same cycle.
- Reset mid-scan restarts from digit 0, counter 0.
- Write decode applies only when ioWrite==1; exact 32-bit address match:
  - 32'hffff_ffc1: led <= data
  - 32'hffff_ffc3: led[15:8] <= data[7:0]; led[7:0] unchanged
  - 32'hffff_ffc5: led[7:0] <= data[7:0]; led[15:8] unchanged
  - 32'hffff_ffd1: value[15:0] <= data
  - 32'hffff_ffd3: value[31:16] <= data
  - 32'hffff_ffd5: mask <= data[7:0]
  - Any other address: no register changes, no error.
  - ioWrite==0: no register changes regardless of address.
- Write latency: register updates on the edge where ioWrite is sampled high; led reflects it the following cycle.
- Scan counter:
  - Increments every cycle.
  - When counter==SCAN_DIV-1: counter resets to 0 and digit index increments mod 8 (7 wraps to 0).
- Output register, updated every cycle from the current (pre-edge) digit index d, value, and mask:
  - If mask[d]==1: seg_an = ~(8'b1<<d); seg_out = active-low pattern of nibble value[4d+3:4d]; dp always off (bit7=1).
  - If mask[d]==0: seg_an=8'hFF, seg_out=8'hFF.
- Display latency: a value or mask write becomes visible at most 2 cycles after the write edge if that digit is being scanned; otherwise when the digit is next scanned.
- Hex font, active-low, order {g,f,e,d,c,b,a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Exactly one anode is low at any time when the scanned digit is enabled; never more than one.
- Writes during scanning do not disturb counter or digit index.

Test Plan:
- Reset: hold rst=0 3 cycles with ioWrite=1, addr ffff_ffc1, data FFFF -> led=0000, seg_an=FF, seg_out=FF; release -> led stays 0.
- LED writes: write ffff_ffc1 data A5C3 -> led=A5C3 next cycle. Write ffff_ffc3 data 0012 -> led=12C3. Write ffff_ffc5 data 0034 -> led=1234. Write ffff_ffc7 data FFFF -> led=1234. ioWrite=0 on ffff_ffc1 -> unchanged.
- Scan: SCAN_DIV=4; write d1=CDEF, d3=89AB.
  - Each digit is held 4 cycles; seg_an walks FE,FD,...,7F then wraps to FE.
  - Digit0 shows F (0001110 with dp=1, seg_out=8'h8E); digit7 shows 8 (seg_out=8'h80).
- Mask: write ffff_ffd5 data 00F0 -> digits 0-3 show seg_an=FF, seg_out=FF while scanned; digits 4-7 lit normally. Never two anodes low simultaneously.
- Mid-digit update: while digit 2 is lit, write ffff_ffd1 data 0500 -> seg_out changes to the "5" pattern (8'h92) within 2 cycles; scan timing unchanged.
- Reset mid-scan at digit 5 -> next cycles seg_an=FF, then digit 0 restarts with mask FF and value 0 (seg_out=8'hC0).
